// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg
//   Shared definitions for the programmable counter: run-mode encodings and
//   the one-shot FSM state type.
package prog_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    // 2'b11 is reserved and decodes as wrap.

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } os_state_t;

endpackage

// File: rtl/prog_counter_if.sv
// prog_counter_if
//   Control/observation bundle for prog_counter.
//   master: drives load, load_data, count_en, dir, mode, start, limit;
//           observes count, tc, running, done.
//   slave : the counter side (mirror of master).
interface prog_counter_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             count_en;
    logic             dir;
    logic [1:0]       mode;
    logic             start;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;
    logic             done;

    modport master (
        output load, load_data, count_en, dir, mode, start, limit,
        input  count, tc, running, done
    );

    modport slave (
        input  load, load_data, count_en, dir, mode, start, limit,
        output count, tc, running, done
    );
endinterface

// File: rtl/prog_counter_prescaler.sv
// prog_counter_prescaler
//   Enable divider: asserts tick on every PRESCALE-th enabled cycle.
//   Ports: clk, rst (sync, active-high), clr (sync clear of the phase),
//          en (count enable), tick (combinational from en and phase register).
//   With PRESCALE=1 there is no state and tick follows en.
module prog_counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr};
            assign tick = en;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase_reg;

            // Phase only advances on enabled cycles, so gaps in en stretch
            // the period rather than losing progress.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    phase_reg <= '0;
                end else if (en) begin
                    phase_reg <= (phase_reg == LAST) ? '0 : phase_reg + PW'(1);
                end
            end

            assign tick = en && (phase_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/prog_counter.sv
// prog_counter
//   WIDTH-bit up/down counter with inclusive programmable upper limit,
//   wrap / saturate / one-shot run modes, enable prescaler and registered
//   one-cycle terminal-count pulse.
//   Ports: clk, rst (sync, active-high), bus (prog_counter_if.slave):
//     load/load_data, count_en, dir, mode, start, limit in;
//     count, tc, running, done out (all derived from registers only).
//   Edge priority: rst > load > start > tick.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    prog_counter_if.slave   bus
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
    os_state_t        state_reg, state_next;

    logic             tick;
    logic             start_accept;
    logic             presc_clr;

    logic             up_bound, dn_bound, over, at_bound;
    logic [WIDTH-1:0] wrap_count, sat_count;
    logic             wrap_tc, sat_tc;
    logic             running, done;

    // A start only counts when it actually arms the one-shot; otherwise it
    // neither blocks the tick nor disturbs the prescaler phase.
    assign start_accept = bus.start && !bus.load && (bus.mode == MODE_ONESHOT)
                          && (state_reg != RUN);
    assign presc_clr    = bus.load || start_accept;

    prog_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (bus.count_en),
        .tick (tick)
    );

    // Bound compare; ">=" on the up side also catches a count left above
    // the limit by a load or a limit change.
    assign up_bound = (count_reg >= bus.limit);
    assign dn_bound = (count_reg == '0);
    assign over     = (count_reg > bus.limit);
    assign at_bound = bus.dir ? dn_bound : up_bound;

    // Wrap-mode successor.
    always_comb begin
        wrap_count = count_reg;
        wrap_tc    = 1'b0;
        if (!bus.dir) begin
            if (up_bound) begin
                wrap_count = '0;
                wrap_tc    = 1'b1;
            end else begin
                wrap_count = count_reg + WIDTH'(1);
            end
        end else begin
            if (dn_bound) begin
                wrap_count = bus.limit;
                wrap_tc    = 1'b1;
            end else if (over) begin
                // Out of range while counting down: pull back into [0, limit].
                wrap_count = bus.limit;
            end else begin
                wrap_count = count_reg - WIDTH'(1);
            end
        end
    end

    // Saturate-mode successor; tc marks the tick that lands on the bound.
    always_comb begin
        sat_count = count_reg;
        sat_tc    = 1'b0;
        if (!bus.dir) begin
            if (over) begin
                sat_count = bus.limit;
                sat_tc    = 1'b1;
            end else if (!up_bound) begin
                sat_count = count_reg + WIDTH'(1);
                sat_tc    = (sat_count == bus.limit);
            end
        end else begin
            if (over) begin
                sat_count = bus.limit;
                sat_tc    = (bus.limit == '0);
            end else if (!dn_bound) begin
                sat_count = count_reg - WIDTH'(1);
                sat_tc    = (sat_count == '0);
            end
        end
    end

    // Count / tc next value.
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        if (bus.load) begin
            count_next = bus.load_data;
        end else if (start_accept) begin
            count_next = count_reg;
        end else if (tick) begin
            case (bus.mode)
                MODE_SAT: begin
                    count_next = sat_count;
                    tc_next    = sat_tc;
                end
                MODE_ONESHOT: begin
                    // Only RUN counts; a tick already sitting on the bound
                    // still ends the run with a pulse.
                    if (state_reg == RUN) begin
                        count_next = sat_count;
                        tc_next    = sat_tc || at_bound;
                    end
                end
                default: begin
                    count_next = wrap_count;
                    tc_next    = wrap_tc;
                end
            endcase
        end
    end

    // One-shot FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // One-shot FSM: next state. Any mode other than one-shot parks it in
    // IDLE, so re-entering one-shot always starts from IDLE.
    always_comb begin
        state_next = state_reg;
        if (bus.mode != MODE_ONESHOT) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_accept) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!bus.load && tick && (sat_tc || at_bound)) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // One-shot FSM: outputs, decoded from the state register only.
    always_comb begin
        running = (state_reg == RUN);
        done    = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
        end
    end

    assign bus.count   = count_reg;
    assign bus.tc      = tc_reg;
    assign bus.running = running;
    assign bus.done    = done;

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter
//   Scoreboard bench for prog_counter: the driver applies inputs after each
//   falling edge and queues the state expected after the next rising edge;
//   a monitor pops and compares shortly after every rising edge.
//   dut1: WIDTH=8, PRESCALE=1.  dut2: WIDTH=8, PRESCALE=4.
module tb_prog_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prog_counter_if #(.WIDTH(8)) bus1 ();
    prog_counter_if #(.WIDTH(8)) bus2 ();

    prog_counter #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    prog_counter #(.WIDTH(8), .PRESCALE(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        string      name;
        logic [7:0] count;
        logic       tc;
        logic       running;
        logic       done;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int checks   = 0;
    int failures = 0;

    task automatic exp1(input string nm, input logic [7:0] c, input logic t,
                        input logic r, input logic d);
        q1.push_back('{nm, c, t, r, d});
    endtask

    task automatic exp2(input string nm, input logic [7:0] c, input logic t,
                        input logic r, input logic d);
        q2.push_back('{nm, c, t, r, d});
    endtask

    task automatic compare(input int id, input exp_t e, input logic [7:0] c,
                           input logic t, input logic r, input logic d);
        checks++;
        if (c !== e.count || t !== e.tc || r !== e.running || d !== e.done) begin
            failures++;
            $display("FAIL %s dut%0d: got count=%h tc=%b running=%b done=%b, want count=%h tc=%b running=%b done=%b",
                     e.name, id, c, t, r, d, e.count, e.tc, e.running, e.done);
        end else begin
            $display("ok   %s dut%0d: count=%h tc=%b running=%b done=%b",
                     e.name, id, c, t, r, d);
        end
    endtask

    // Monitor: one expectation per DUT per clock at most.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            compare(1, q1.pop_front(), bus1.count, bus1.tc, bus1.running, bus1.done);
        end
        if (q2.size() > 0) begin
            compare(2, q2.pop_front(), bus2.count, bus2.tc, bus2.running, bus2.done);
        end
    end

    // Prescaler table: enable per cycle and count expected after that edge.
    logic       en_tab  [21] = '{1,1,1,1,1,1,1,1,1,1,1,1,1, 0,0, 1,1,1,1,1,1};
    logic [7:0] cnt_tab [21] = '{0,0,0,1,1,1,1,2,2,2,2,3,3, 3,3, 3,3,4,4,4,4};

    initial begin
        bus1.load = 0; bus1.load_data = '0; bus1.count_en = 0; bus1.dir = 0;
        bus1.mode = 2'b00; bus1.start = 0; bus1.limit = '0;
        bus2.load = 0; bus2.load_data = '0; bus2.count_en = 0; bus2.dir = 0;
        bus2.mode = 2'b00; bus2.start = 0; bus2.limit = 8'hFF;

        // Reset and load
        @(negedge clk); rst = 1; exp1("reset", 8'h00, 0, 0, 0);
        @(negedge clk); rst = 0; bus1.load = 1; bus1.load_data = 8'hFE;
        exp1("load_fe", 8'hFE, 0, 0, 0);

        // Wrap up, limit 9
        @(negedge clk); bus1.load_data = 8'h00; bus1.limit = 8'd9;
        exp1("load_0", 8'h00, 0, 0, 0);
        @(negedge clk); bus1.load = 0; bus1.count_en = 1;
        for (int i = 1; i <= 10; i++) begin
            exp1("wrap_up", 8'(i % 10), (i == 10), 0, 0);
            if (i < 10) @(negedge clk);
        end
        // Wrap down from 0
        @(negedge clk); bus1.dir = 1; exp1("wrap_dn_0", 8'd9, 1, 0, 0);
        @(negedge clk); exp1("wrap_dn", 8'd8, 0, 0, 0);
        // limit = 0 wrap up: pulse every tick
        @(negedge clk); bus1.dir = 0; bus1.limit = 8'd0; exp1("lim0_a", 8'd0, 1, 0, 0);
        @(negedge clk); exp1("lim0_b", 8'd0, 1, 0, 0);

        // Saturate, limit 5
        @(negedge clk); bus1.mode = 2'b01; bus1.limit = 8'd5; bus1.count_en = 0;
        bus1.load = 1; bus1.load_data = 8'd3; exp1("sat_load3", 8'd3, 0, 0, 0);
        @(negedge clk); bus1.load = 0; bus1.count_en = 1; exp1("sat_up4", 8'd4, 0, 0, 0);
        @(negedge clk); exp1("sat_up5", 8'd5, 1, 0, 0);
        @(negedge clk); exp1("sat_hold1", 8'd5, 0, 0, 0);
        @(negedge clk); exp1("sat_hold2", 8'd5, 0, 0, 0);
        @(negedge clk); exp1("sat_hold3", 8'd5, 0, 0, 0);
        @(negedge clk); bus1.load = 1; bus1.load_data = 8'hC8; exp1("sat_load_c8", 8'hC8, 0, 0, 0);
        @(negedge clk); bus1.load = 0; exp1("sat_over", 8'd5, 1, 0, 0);
        @(negedge clk); exp1("sat_over_hold", 8'd5, 0, 0, 0);
        // Saturate down
        @(negedge clk); bus1.dir = 1; exp1("sat_dn4", 8'd4, 0, 0, 0);
        @(negedge clk); exp1("sat_dn3", 8'd3, 0, 0, 0);
        @(negedge clk); exp1("sat_dn2", 8'd2, 0, 0, 0);
        @(negedge clk); exp1("sat_dn1", 8'd1, 0, 0, 0);
        @(negedge clk); exp1("sat_dn0", 8'd0, 1, 0, 0);
        @(negedge clk); exp1("sat_dn_hold", 8'd0, 0, 0, 0);

        // Load beats tick
        @(negedge clk); bus1.mode = 2'b00; bus1.limit = 8'd9; bus1.dir = 0;
        bus1.load = 1; bus1.load_data = 8'd7; exp1("prio_load", 8'd7, 0, 0, 0);
        @(negedge clk); bus1.load = 0; exp1("prio_tick8", 8'd8, 0, 0, 0);
        @(negedge clk); exp1("prio_tick9", 8'd9, 0, 0, 0);
        // Reset beats load
        @(negedge clk); rst = 1; bus1.load = 1; bus1.load_data = 8'h55;
        exp1("rst_vs_load", 8'd0, 0, 0, 0);

        // One-shot, limit 3
        @(negedge clk); rst = 0; bus1.mode = 2'b10; bus1.limit = 8'd3;
        bus1.count_en = 0; bus1.load = 1; bus1.load_data = 8'd0;
        exp1("os_load0", 8'd0, 0, 0, 0);
        @(negedge clk); bus1.load = 0; bus1.count_en = 1; exp1("os_idle_hold", 8'd0, 0, 0, 0);
        @(negedge clk); bus1.count_en = 0; bus1.start = 1; exp1("os_start", 8'd0, 0, 1, 0);
        @(negedge clk); bus1.start = 0; bus1.count_en = 1; exp1("os_run1", 8'd1, 0, 1, 0);
        @(negedge clk); exp1("os_run2", 8'd2, 0, 1, 0);
        @(negedge clk); exp1("os_run3_done", 8'd3, 1, 0, 1);
        @(negedge clk); exp1("os_done_hold1", 8'd3, 0, 0, 1);
        @(negedge clk); exp1("os_done_hold2", 8'd3, 0, 0, 1);
        @(negedge clk); bus1.start = 1; exp1("os_rearm", 8'd3, 0, 1, 0);
        @(negedge clk); bus1.start = 0; exp1("os_armed_at_bound", 8'd3, 1, 0, 1);
        // Load keeps FSM state, then mode change during RUN
        @(negedge clk); bus1.count_en = 0; bus1.load = 1; bus1.load_data = 8'd0;
        exp1("os_load_keeps_done", 8'd0, 0, 0, 1);
        @(negedge clk); bus1.load = 0; bus1.start = 1; exp1("os_start2", 8'd0, 0, 1, 0);
        @(negedge clk); bus1.start = 0; bus1.count_en = 1; exp1("os_run_b1", 8'd1, 0, 1, 0);
        @(negedge clk); bus1.mode = 2'b00; exp1("mode_leave", 8'd2, 0, 0, 0);
        @(negedge clk); exp1("mode_wrap_cont", 8'd3, 0, 0, 0);
        @(negedge clk); bus1.count_en = 0;

        // Prescaler = 4 on dut2
        @(negedge clk); rst = 1; exp2("ps_reset", 8'd0, 0, 0, 0);
        @(negedge clk); rst = 0;
        for (int i = 0; i < 21; i++) begin
            bus2.count_en = en_tab[i];
            exp2($sformatf("ps_cyc%0d", i + 1), cnt_tab[i], 0, 0, 0);
            @(negedge clk);
        end
        bus2.count_en = 0;

        // Drain, bounded
        for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        if (q1.size() > 0 || q2.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d/%0d expectations left, want 0", q1.size(), q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
